// File: rtl/register_file_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_DEPTH),
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_pending,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    input  logic                         i_issue_en,
    input  logic [ADDR_WIDTH-1:0]        i_issue_addr,
    output logic [REG_DEPTH-1:0]         o_pending_vec
);

    logic [DATA_WIDTH-1:0] mem_q [REG_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [REG_DEPTH];
    logic [REG_DEPTH-1:0]  pend_q;
    logic [REG_DEPTH-1:0]  pend_d;

    // x0 and indices beyond the last register are treated as "no register".
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < REG_DEPTH);
    endfunction

    // Later write ports overwrite earlier ones; issue is applied last so set beats clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && addr_ok(i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                mem_d[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]]  = i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                pend_d[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (i_issue_en && addr_ok(i_issue_addr)) begin
            pend_d[i_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int r = 0; r < REG_DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign o_pending_vec = pend_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] rd_data;
            logic                  rd_pend;

            assign rd_addr = i_rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                rd_data = '0;
                rd_pend = 1'b0;
                if (addr_ok(rd_addr)) begin
                    rd_data = mem_q[rd_addr];
                    rd_pend = pend_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
                    // Forward in-flight write data; the highest matching port wins.
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (i_wr_en[j] && (i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
                            rd_data = i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                            if (!(i_issue_en && (i_issue_addr == rd_addr))) begin
                                rd_pend = 1'b0;
                            end
                        end
                    end
`endif
                end
            end

            assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            assign o_rd_pending[gi]                       = rd_pend;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Directed test of register_file_mp: reset, x0, scoreboard, collisions and forwarding.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it defined.
module tb_register_file_mp;

    localparam int DW = 64;
    localparam int RD = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             arst;
    logic [NR*AW-1:0] i_rd_addr;
    logic [NR*DW-1:0] o_rd_data;
    logic [NR-1:0]    o_rd_pending;
    logic [NW-1:0]    i_wr_en;
    logic [NW*AW-1:0] i_wr_addr;
    logic [NW*DW-1:0] i_wr_data;
    logic             i_issue_en;
    logic [AW-1:0]    i_issue_addr;
    logic [RD-1:0]    o_pending_vec;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_mp #(
        .DATA_WIDTH(DW), .REG_DEPTH(RD), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW)
    ) dut (
        .clk(clk), .arst(arst),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_pending(o_rd_pending),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_issue_en(i_issue_en), .i_issue_addr(i_issue_addr),
        .o_pending_vec(o_pending_vec)
    );

    logic [DW-1:0] rd0, rd1;
    assign rd0 = o_rd_data[0 +: DW];
    assign rd1 = o_rd_data[DW +: DW];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        arst = 1'b0; i_wr_en = '0; i_wr_addr = '0; i_wr_data = '0;
        i_issue_en = 1'b0; i_issue_addr = '0; i_rd_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("cycle t=%0t rst=%b wr_en=%b wr_addr=%h issue=%b/%0d vec=%h",
                 $time, arst, i_wr_en, i_wr_addr, i_issue_en, i_issue_addr, o_pending_vec);
    endtask

    task automatic set_rd(input int a0, input int a1);
        i_rd_addr[0 +: AW]  = AW'(a0);
        i_rd_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic set_wr(input int port, input int addr, input logic [DW-1:0] data);
        i_wr_en[port]             = 1'b1;
        i_wr_addr[port*AW +: AW]  = AW'(addr);
        i_wr_data[port*DW +: DW]  = data;
    endtask

    task automatic issue(input int addr);
        i_issue_en   = 1'b1;
        i_issue_addr = AW'(addr);
    endtask

    task automatic do_reset();
        idle();
        arst = 1'b1;
        tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_rd(5, 7); #1;
        n_checks++; if (o_pending_vec !== 32'h0) begin n_fail++; $display("FAIL reset_vec got=%h exp=0", o_pending_vec); end
        n_checks++; if (rd0 !== 64'h0 || rd1 !== 64'h0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", rd0, rd1); end
        n_checks++; if (o_rd_pending !== 2'b00) begin n_fail++; $display("FAIL reset_rdpend got=%b exp=00", o_rd_pending); end

        set_wr(0, 5, 64'hDEAD); issue(7);
        tick(); idle(); set_rd(5, 7); #1;
        n_checks++; if (rd0 !== 64'hDEAD) begin n_fail++; $display("FAIL prereset_x5 got=%h exp=dead", rd0); end
        n_checks++; if (o_pending_vec !== 32'h80) begin n_fail++; $display("FAIL prereset_vec got=%h exp=80", o_pending_vec); end
        n_checks++; if (o_rd_pending !== 2'b10) begin n_fail++; $display("FAIL prereset_rdpend got=%b exp=10", o_rd_pending); end

        arst = 1'b1; set_wr(0, 6, 64'h66); issue(9);
        tick(); idle(); set_rd(5, 6); #1;
        n_checks++; if (rd0 !== 64'h0 || rd1 !== 64'h0) begin n_fail++; $display("FAIL flush_data got=%h/%h exp=0/0", rd0, rd1); end
        n_checks++; if (o_pending_vec !== 32'h0) begin n_fail++; $display("FAIL flush_vec got=%h exp=0", o_pending_vec); end
    endtask

    task automatic test_x0();
        do_reset();
        set_wr(0, 0, '1); set_wr(1, 0, '1); issue(0); set_rd(0, 0); #1;
        n_checks++; if (rd0 !== 64'h0 || rd1 !== 64'h0) begin n_fail++; $display("FAIL x0_samecycle got=%h/%h exp=0/0", rd0, rd1); end
        n_checks++; if (o_rd_pending !== 2'b00) begin n_fail++; $display("FAIL x0_samecycle_pend got=%b exp=00", o_rd_pending); end
        tick(); idle(); set_rd(0, 0); #1;
        n_checks++; if (rd0 !== 64'h0 || rd1 !== 64'h0) begin n_fail++; $display("FAIL x0_after got=%h/%h exp=0/0", rd0, rd1); end
        n_checks++; if (o_pending_vec !== 32'h0) begin n_fail++; $display("FAIL x0_vec got=%h exp=0", o_pending_vec); end
    endtask

    task automatic test_scoreboard();
        logic [DW-1:0] exp_d;
        logic          exp_p;
        do_reset();
        issue(10); set_rd(10, 10); #1;
        n_checks++; if (o_pending_vec !== 32'h0) begin n_fail++; $display("FAIL sb_cycle0_vec got=%h exp=0", o_pending_vec); end
        tick(); idle(); set_rd(10, 11); #1;
        n_checks++; if (o_pending_vec !== 32'h400) begin n_fail++; $display("FAIL sb_cycle1_vec got=%h exp=400", o_pending_vec); end
        n_checks++; if (o_rd_pending !== 2'b01) begin n_fail++; $display("FAIL sb_cycle1_rdpend got=%b exp=01", o_rd_pending); end
        tick(); tick();
        n_checks++; if (o_pending_vec !== 32'h400) begin n_fail++; $display("FAIL sb_hold_vec got=%h exp=400", o_pending_vec); end
        set_wr(0, 10, 64'h1234); set_rd(10, 10); #1;
        exp_d = BYP ? 64'h1234 : 64'h0;
        exp_p = BYP ? 1'b0 : 1'b1;
        n_checks++; if (rd0 !== exp_d) begin n_fail++; $display("FAIL sb_wr_cycle_data got=%h exp=%h", rd0, exp_d); end
        n_checks++; if (o_rd_pending[0] !== exp_p) begin n_fail++; $display("FAIL sb_wr_cycle_pend got=%b exp=%b", o_rd_pending[0], exp_p); end
        tick(); idle(); set_rd(10, 10); #1;
        n_checks++; if (rd0 !== 64'h1234) begin n_fail++; $display("FAIL sb_after_data got=%h exp=1234", rd0); end
        n_checks++; if (o_pending_vec !== 32'h0 || o_rd_pending !== 2'b00) begin n_fail++; $display("FAIL sb_after_pend got=%h/%b exp=0/00", o_pending_vec, o_rd_pending); end
    endtask

    task automatic test_set_clear();
        logic [DW-1:0] exp_d;
        do_reset();
        issue(3); tick(); idle();
        set_wr(0, 3, 64'h55); issue(3); set_rd(3, 3); #1;
        exp_d = BYP ? 64'h55 : 64'h0;
        n_checks++; if (rd0 !== exp_d) begin n_fail++; $display("FAIL setclr_cycle_data got=%h exp=%h", rd0, exp_d); end
        n_checks++; if (o_rd_pending !== 2'b11) begin n_fail++; $display("FAIL setclr_cycle_pend got=%b exp=11", o_rd_pending); end
        tick(); idle(); set_rd(3, 3); #1;
        n_checks++; if (rd0 !== 64'h55) begin n_fail++; $display("FAIL setclr_data got=%h exp=55", rd0); end
        n_checks++; if (o_pending_vec !== 32'h8) begin n_fail++; $display("FAIL setclr_vec got=%h exp=8", o_pending_vec); end
    endtask

    task automatic test_dual_write();
        logic [DW-1:0] exp_d;
        do_reset();
        set_wr(0, 8, 64'hAA); set_wr(1, 8, 64'hBB); set_rd(8, 8); #1;
        exp_d = BYP ? 64'hBB : 64'h0;
        n_checks++; if (rd0 !== exp_d || rd1 !== exp_d) begin n_fail++; $display("FAIL dual_cycle got=%h/%h exp=%h", rd0, rd1, exp_d); end
        tick(); idle(); set_rd(8, 8); #1;
        n_checks++; if (rd0 !== 64'hBB || rd1 !== 64'hBB) begin n_fail++; $display("FAIL dual_after got=%h/%h exp=bb", rd0, rd1); end
        set_wr(0, 13, 64'h1313); set_wr(1, 14, 64'h1414);
        tick(); idle(); set_rd(13, 14); #1;
        n_checks++; if (rd0 !== 64'h1313 || rd1 !== 64'h1414) begin n_fail++; $display("FAIL dual_distinct got=%h/%h exp=1313/1414", rd0, rd1); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_d;
        do_reset();
        set_wr(0, 12, 64'h11); tick(); idle();
        set_wr(0, 12, 64'h77); set_rd(12, 12); #1;
        exp_d = BYP ? 64'h77 : 64'h11;
        n_checks++; if (rd0 !== exp_d || rd1 !== exp_d) begin n_fail++; $display("FAIL byp_cycle got=%h/%h exp=%h", rd0, rd1, exp_d); end
        n_checks++; if (o_rd_pending !== 2'b00) begin n_fail++; $display("FAIL byp_cycle_pend got=%b exp=00", o_rd_pending); end
        tick(); idle(); set_rd(12, 12); #1;
        n_checks++; if (rd0 !== 64'h77 || rd1 !== 64'h77) begin n_fail++; $display("FAIL byp_after got=%h/%h exp=77", rd0, rd1); end
        n_checks++; if (o_pending_vec !== 32'h0) begin n_fail++; $display("FAIL byp_vec got=%h exp=0", o_pending_vec); end
    endtask

    initial begin
        idle();
        test_reset();
        test_x0();
        test_scoreboard();
        test_set_clear();
        test_dual_write();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
